// File: rtl/permutation_ctrl.sv
// Round sequencer for the Ascon permutation datapath: runs p^a or p^b by
// stepping the datapath enable/select/round inputs and pulsing done at the end.
module permutation_ctrl #(
    parameter int unsigned PA_ROUNDS = 12,
    parameter int unsigned PB_ROUNDS = 6
) (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic       mode_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       enable_o,
    output logic       select_o,
    output logic [3:0] round_o
);

    localparam int unsigned RW         = 4;
    localparam int unsigned MAX_ROUNDS = 12;
    localparam logic [RW-1:0] LAST_ROUND = RW'(MAX_ROUNDS - 1);
    localparam logic [RW-1:0] PA_START   = RW'(MAX_ROUNDS - PA_ROUNDS);
    localparam logic [RW-1:0] PB_START   = RW'(MAX_ROUNDS - PB_ROUNDS);

    // Round counts outside 1..12 would push the start index out of the Pc table
    if (PA_ROUNDS < 1 || PA_ROUNDS > MAX_ROUNDS) begin : g_bad_pa
        $error("permutation_ctrl: PA_ROUNDS must be in 1..12");
    end
    if (PB_ROUNDS < 1 || PB_ROUNDS > MAX_ROUNDS) begin : g_bad_pb
        $error("permutation_ctrl: PB_ROUNDS must be in 1..12");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_nxt;
    logic [RW-1:0]   cnt_q, cnt_nxt;

    // State and round counter registers
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    // Next-state and counter update; the counter saturates at the last round
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    cnt_nxt   = mode_i ? PB_START : PA_START;
                    state_nxt = ST_FIRST;
                end
            end
            ST_FIRST, ST_ROUND: begin
                if (cnt_q == LAST_ROUND) begin
                    state_nxt = ST_DONE;
                end else begin
                    cnt_nxt   = cnt_q + RW'(1);
                    state_nxt = ST_ROUND;
                end
            end
            ST_DONE: begin
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Moore output decode; reset of the registers clears outputs immediately
    always_comb begin
        busy_o   = 1'b0;
        done_o   = 1'b0;
        enable_o = 1'b0;
        select_o = 1'b0;
        round_o  = '0;
        case (state_q)
            ST_FIRST: begin
                busy_o   = 1'b1;
                enable_o = 1'b1;
                round_o  = cnt_q;
            end
            ST_ROUND: begin
                busy_o   = 1'b1;
                enable_o = 1'b1;
                select_o = 1'b1;
                round_o  = cnt_q;
            end
            ST_DONE: begin
                done_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_permutation_ctrl.sv
// Scoreboard bench: a schedule model pushes expected per-cycle outputs for two
// sequencers (defaults and PB_ROUNDS=1); a monitor pops and compares each cycle.
module tb_permutation_ctrl;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       en;
        logic       sel;
        logic [3:0] rnd;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic mode = 1'b0;

    logic       busy0, done0, en0, sel0;
    logic [3:0] rnd0;
    logic       busy1, done1, en1, sel1;
    logic [3:0] rnd1;

    int n_cmp = 0;
    int n_bad = 0;

    obs_t q0[$];
    obs_t q1[$];

    always #5 clk = ~clk;

    permutation_ctrl u_dflt (
        .clock_i(clk), .resetb_i(rst_n), .start_i(start), .mode_i(mode),
        .busy_o(busy0), .done_o(done0), .enable_o(en0), .select_o(sel0), .round_o(rnd0)
    );

    permutation_ctrl #(.PA_ROUNDS(12), .PB_ROUNDS(1)) u_n1 (
        .clock_i(clk), .resetb_i(rst_n), .start_i(start), .mode_i(mode),
        .busy_o(busy1), .done_o(done1), .enable_o(en1), .select_o(sel1), .round_o(rnd1)
    );

    function automatic obs_t mk(input logic b, input logic d, input logic e,
                                input logic s, input int r);
        obs_t o;
        o.busy = b; o.done = d; o.en = e; o.sel = s; o.rnd = 4'(r);
        return o;
    endfunction

    // A run of n rounds: rounds 12-n..11 with feedback after the first,
    // one done cycle, then one mandatory idle cycle before a new start.
    task automatic schedule(input int which, input int n);
        for (int k = 0; k < n; k++) begin
            if (which == 0) q0.push_back(mk(1'b1, 1'b0, 1'b1, k != 0, 12 - n + k));
            else            q1.push_back(mk(1'b1, 1'b0, 1'b1, k != 0, 12 - n + k));
        end
        if (which == 0) begin
            q0.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 0));
            q0.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 0));
        end else begin
            q1.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 0));
            q1.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 0));
        end
    endtask

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got busy=%b done=%b en=%b sel=%b rnd=%0d, want busy=%b done=%b en=%b sel=%b rnd=%0d",
                     name, $time, act.busy, act.done, act.en, act.sel, act.rnd,
                     exp.busy, exp.done, exp.en, exp.sel, exp.rnd);
        end
    endtask

    // Reference model: a start is taken only when nothing is scheduled
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
        end else if (start) begin
            if (q0.size() == 0) schedule(0, mode ? 6 : 12);
            if (q1.size() == 0) schedule(1, mode ? 1 : 12);
        end
    end

    // Monitor: an empty schedule means the sequencer must sit idle
    always @(negedge clk) begin
        obs_t e0, e1;
        e0 = (q0.size() != 0) ? q0.pop_front() : mk(1'b0, 1'b0, 1'b0, 1'b0, 0);
        e1 = (q1.size() != 0) ? q1.pop_front() : mk(1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("dflt_cycle", {busy0, done0, en0, sel0, rnd0}, e0);
        check("n1_cycle",   {busy1, done1, en1, sel1, rnd1}, e1);
    end

    task automatic drive(input logic s, input logic m);
        @(negedge clk);
        start = s;
        mode  = m;
    endtask

    initial begin
        int waited;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) drive(1'b0, 1'b0);

        // Single p^a, then single p^b with start/mode toggling mid-run
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b1);
        repeat (5) drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        repeat (10) drive(1'b0, 1'b0);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b0);
        repeat (4) drive(1'b1, 1'b0);
        repeat (6) drive(1'b0, 1'b0);

        // Back-to-back p^a with start held high
        repeat (45) drive(1'b1, 1'b0);
        repeat (16) drive(1'b0, 1'b0);

        // Asynchronous reset in the middle of a p^a run
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        waited = 0;
        while (!(sel0 && rnd0 >= 4'd3) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (waited >= 50) begin
            n_bad++;
            $display("FAIL reset_wait: round 3 not reached within %0d cycles, want <50", waited);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_dflt", {busy0, done0, en0, sel0, rnd0}, mk(1'b0, 1'b0, 1'b0, 1'b0, 0));
        check("async_rst_n1",   {busy1, done1, en1, sel1, rnd1}, mk(1'b0, 1'b0, 1'b0, 1'b0, 0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (16) drive(1'b0, 1'b0);

        // Randomized starts and modes
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 3) == 0, 1'($urandom));
        end
        repeat (20) drive(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/permutation_ctrl.md
# permutation_ctrl

Round sequencer for the Ascon permutation datapath. It accepts a start request for either the p^a (12-round) or p^b (6-round) permutation. It then drives the datapath's `enable`, `select` and `round` inputs cycle by cycle, and reports completion with a one-cycle done pulse. It sits between the Ascon top-level FSM and the permutation datapath, which consists of the state mux, the Pc/Ps/Pl layers and the state register with enable.

## Interface
Parameters:
- `PA_ROUNDS`, default 12: rounds executed when `mode_i`=0. Legal range 1..12.
- `PB_ROUNDS`, default 6: rounds executed when `mode_i`=1. Legal range 1..12.

Ports:
- `clock_i`  in  1: single clock, rising edge.
- `resetb_i`  in  1: reset. Asynchronous and active-low.
- `start_i`  in  1: start request. Sampled only in IDLE.
- `mode_i`  in  1: permutation select, 0 = p^a, 1 = p^b. Sampled together with an accepted `start_i`.
- `busy_o`  out  1: high while a permutation is in progress (FIRST or ROUND).
- `done_o`  out  1: one-cycle pulse after the last round is written.
- `enable_o`  out  1: to datapath state-register enable.
- `select_o`  out  1: to datapath mux. 0 = external `data_i`, 1 = register feedback.
- `round_o`  out  4: round index to Pc (constant-addition) layer, range 0..11.

## Operation
- FSM states are IDLE, FIRST, ROUND and DONE. The state and a 4-bit round counter are registered. All outputs are decoded combinationally from these registers only (Moore); no input reaches an output combinationally.
- **IDLE.** All outputs are 0.
  - If `start_i`=1 at a clock edge: latch `mode_i`, load counter with start index S = 12 − N (N = `PA_ROUNDS` or `PB_ROUNDS`), go to FIRST.
- **FIRST.** `enable_o`=1, `select_o`=0, `round_o`=S, `busy_o`=1.
  - At the edge: counter increments. If S = 11 (N = 1), go to DONE; else go to ROUND.
- **ROUND.** `enable_o`=1, `select_o`=1, `round_o`=counter, `busy_o`=1.
  - At each edge: if counter = 11, go to DONE; else increment counter.
- **DONE.** `done_o`=1, `enable_o`=0, `select_o`=0, `busy_o`=0, `round_o`=0. Next edge goes to IDLE unconditionally.
- `start_i` in FIRST, ROUND or DONE is ignored; it is neither queued nor remembered. `mode_i` changes after acceptance have no effect.
- The counter never exceeds 11 and never wraps. For the defaults:
  - p^a issues round indices 0,1,…,11.
  - p^b issues round indices 6,7,…,11.
- Parameter values outside 1..12 are illegal. The implementation flags them with an elaboration-time assertion.
- Asserting `resetb_i` low at any time, including mid-permutation, forces IDLE and counter = 0 immediately. All outputs go to 0 without waiting for a clock edge. No done pulse is issued for an aborted permutation.

## Timing
- Reset values: `busy_o`=0, `done_o`=0, `enable_o`=0, `select_o`=0, `round_o`=0, state = IDLE.
- Let `start_i` be accepted at edge E0:
  - FIRST occupies the cycle after E0.
  - Round k (k = 0..N−1) occupies cycle k+1 after E0.
  - `done_o` is high in cycle N+1. IDLE is reached in cycle N+2.
- Totals with defaults:
  - p^a: 12 `enable_o` cycles, `done_o` in cycle 13, earliest next accepted start at the edge ending cycle 14 (i.e. the first IDLE cycle).
  - p^b: 6 `enable_o` cycles, `done_o` in cycle 7.
- Permutation result is valid at datapath `data_o` from the `done_o` cycle onward. It is held while `enable_o`=0.
- `start_i` held continuously high gives back-to-back runs with one DONE cycle and one IDLE cycle between them.

## Test plan
- **Reset values.** Apply reset, release, idle 5 cycles → all outputs 0. Apply a mid-cycle async reset pulse during ROUND → outputs 0 before the next edge; no `done_o` follows.
- **p^a run.** `start_i`=1, `mode_i`=0 for one cycle →
  - `round_o` sequence 0..11 over 12 cycles, `enable_o`=1 throughout.
  - `select_o`=0 only on round 0.
  - `done_o` exactly one cycle, 13 cycles after acceptance.
  - With the datapath attached, the output matches the Ascon p^12 golden vector.
- **p^b run.** `mode_i`=1 → `round_o` 6..11 over 6 cycles; `done_o` in cycle 7; output matches the p^6 golden vector.
- **Ignored start.** Pulse `start_i` with `mode_i` toggled during ROUND and during DONE → sequence unchanged; exactly one `done_o`; FSM returns to IDLE and stays there.
- **Back-to-back.** Hold `start_i`=1 with `mode_i`=0 → runs repeat with period 14 cycles; each run restarts `round_o` at 0 with `select_o`=0.
- **N = 1 boundary.** With `PB_ROUNDS`=1, start p^b → single FIRST cycle with `round_o`=11 and `select_o`=0; `done_o` in the next cycle.
